// File: rtl/div_iter_pkg.sv
// Shared CPU package: divider state encoding, widths and constants.
// Also holds a small two's-complement helper used for operand magnitudes and sign fix-up.
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int CNT_WIDTH = 6;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DIV_WIDTH-1:0] negIf(input logic [DIV_WIDTH-1:0] value,
                                                 input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Handshake and operand bus between the execute-stage divide control and the divider.
// master = divide control, slave = divider.
interface div_iter_if;
  import div_iter_pkg::*;

  logic                   start;
  logic                   signed_div;
  logic                   annul;
  logic [DIV_WIDTH-1:0]   opdata1;
  logic [DIV_WIDTH-1:0]   opdata2;
  logic [2*DIV_WIDTH-1:0] result;
  logic                   ready;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output result, ready
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import div_iter_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] partRem,
  input  logic                 nextBit,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH-1:0] newRem,
  output logic                 quotBit
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] diff;

  // One extra bit keeps the trial difference sign-safe for divisors up to 2^32-1.
  always_comb begin
    shifted = {partRem, nextBit};
    diff    = shifted - {1'b0, divisor};
    quotBit = ~diff[DIV_WIDTH];
    newRem  = quotBit ? diff[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/div_iter.sv
// Iterative 32-bit signed/unsigned divider: 32 restoring iterations, one per cycle,
// with registered {remainder, quotient} result and a one-cycle ready pulse.
module div_iter
  import div_iter_pkg::*;
(
  input logic       clk,
  input logic       rst,
  div_iter_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIV_ITERS - 1);

  div_state_t state, nextState;

  logic [CNT_WIDTH-1:0]   cnt;
  logic [DIV_WIDTH-1:0]   remReg;
  logic [DIV_WIDTH-1:0]   quoReg;
  logic [DIV_WIDTH-1:0]   divisorReg;
  logic                   negQuot;
  logic                   negRem;
  logic [2*DIV_WIDTH-1:0] resultReg;
  logic                   readyReg;

  logic [DIV_WIDTH-1:0]   stepRem;
  logic                   stepBit;
  logic                   dividendNeg;
  logic                   divisorNeg;
  logic                   accept;

  div_step u_step (
    .partRem (remReg),
    .nextBit (quoReg[DIV_WIDTH-1]),
    .divisor (divisorReg),
    .newRem  (stepRem),
    .quotBit (stepBit)
  );

  assign dividendNeg = bus.signed_div & bus.opdata1[DIV_WIDTH-1];
  assign divisorNeg  = bus.signed_div & bus.opdata2[DIV_WIDTH-1];
  // annul has priority over start while idle.
  assign accept      = bus.start & ~bus.annul;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = (bus.opdata2 == '0) ? DONE : BUSY;
      BUSY:    if (bus.annul)             nextState = IDLE;
               else if (cnt == LAST_ITER) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: operand registers are plain flops, so they are cleared by reset like the rest;
  // only true RAM arrays would be left unreset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      remReg     <= '0;
      quoReg     <= '0;
      divisorReg <= '0;
      negQuot    <= 1'b0;
      negRem     <= 1'b0;
      resultReg  <= '0;
      readyReg   <= 1'b0;
    end else begin
      readyReg <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (bus.opdata2 == '0) begin
              // Divide-by-zero: preload the final image and skip the sign fix-up.
              remReg     <= bus.opdata1;
              quoReg     <= DIV_ZERO_QUOT;
              divisorReg <= '0;
              negQuot    <= 1'b0;
              negRem     <= 1'b0;
            end else begin
              remReg     <= '0;
              quoReg     <= negIf(bus.opdata1, dividendNeg);
              divisorReg <= negIf(bus.opdata2, divisorNeg);
              negQuot    <= dividendNeg ^ divisorNeg;
              negRem     <= dividendNeg;
            end
          end
        end
        BUSY: begin
          if (!bus.annul) begin
            remReg <= stepRem;
            quoReg <= {quoReg[DIV_WIDTH-2:0], stepBit};
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          resultReg <= {negIf(remReg, negRem), negIf(quoReg, negQuot)};
          readyReg  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = resultReg;
  assign bus.ready  = readyReg;

endmodule
